// File: rtl/primogen_ranged_if.sv
// Request/result bundle for primogen_ranged: go/load/from in, ready/error/res out.
interface primogen_ranged_if #(
    parameter int WIDTH_LOG = 4
);
    localparam int W = 1 << WIDTH_LOG;

    logic         go;
    logic         load;
    logic [W-1:0] from;
    logic         ready;
    logic         error;
    logic [W-1:0] res;

    modport master (output go, load, from, input ready, error, res);
    modport slave  (input go, load, from, output ready, error, res);
endinterface

// File: rtl/primogen_ranged.sv
// Prime generator: trial division of each candidate with a built-in restoring
// remainder unit, searching either after the last result or from a loaded value.
module primogen_ranged #(
    parameter int WIDTH_LOG = 4
) (
    input  logic             clk,
    input  logic             rst,
    primogen_ranged_if.slave bus
);
    localparam int W = 1 << WIDTH_LOG;

    localparam logic [W-1:0]         ONE_W   = 1;
    localparam logic [W-1:0]         TWO_W   = 2;
    localparam logic [W-1:0]         THREE_W = 3;
    localparam logic [W:0]           ONE_X   = 1;
    localparam logic [W:0]           TWO_X   = 2;
    localparam logic [W:0]           THREE_X = 3;
    localparam logic [2*W-1:0]       FOUR_S  = 4;
    localparam logic [2*W-1:0]       NINE_S  = 9;
    localparam logic [WIDTH_LOG-1:0] CNT_ONE = 1;

    typedef enum logic [2:0] {IDLE, ERROR, CHECK, DIV, EVAL} state_t;

    state_t               state_q, state_d;
    logic [W-1:0]         p_q, p_d;
    logic [W-1:0]         d_q, d_d;
    logic [2*W-1:0]       dsq_q, dsq_d;
    logic [W-1:0]         rem_q, rem_d;
    logic [W-1:0]         dvd_q, dvd_d;
    logic [WIDTH_LOG-1:0] cnt_q, cnt_d;
    logic [W-1:0]         res_q, res_d;
    logic                 error_q, error_d;

    logic [W:0] resPlus2;
    logic [W:0] pNext;
    logic [W:0] remShift;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            p_q     <= '0;
            d_q     <= '0;
            dsq_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            cnt_q   <= '0;
            res_q   <= ONE_W;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            d_q     <= d_d;
            dsq_q   <= dsq_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            error_q <= error_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        p_d      = p_q;
        d_d      = d_q;
        dsq_d    = dsq_q;
        rem_d    = rem_q;
        dvd_d    = dvd_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        error_d  = error_q;
        resPlus2 = {1'b0, res_q} + TWO_X;
        // Odd candidates step by two; an even one (only from a load) steps to odd.
        if (p_q == TWO_W)
            pNext = THREE_X;
        else if (p_q[0])
            pNext = {1'b0, p_q} + TWO_X;
        else
            pNext = {1'b0, p_q} + ONE_X;
        remShift = {rem_q, dvd_q[W-1]};

        unique case (state_q)
            IDLE, ERROR: begin
                if (bus.go) begin
                    error_d = 1'b0;
                    d_d     = TWO_W;
                    dsq_d   = FOUR_S;
                    state_d = CHECK;
                    if (bus.load) begin
                        p_d = (bus.from < TWO_W) ? TWO_W : bus.from;
                    end else if (res_q < TWO_W) begin
                        p_d = TWO_W;
                    end else if (res_q == TWO_W) begin
                        p_d = THREE_W;
                    end else if (resPlus2[W]) begin
                        error_d = 1'b1;
                        state_d = ERROR;
                    end else begin
                        p_d = resPlus2[W-1:0];
                    end
                end
            end
            CHECK: begin
                if (dsq_q > {{W{1'b0}}, p_q}) begin
                    res_d   = p_q;
                    state_d = IDLE;
                end else begin
                    rem_d   = '0;
                    dvd_d   = p_q;
                    cnt_d   = '0;
                    state_d = DIV;
                end
            end
            DIV: begin
                // remShift fits W bits after a successful subtract since rem < d.
                if (remShift >= {1'b0, d_q})
                    rem_d = remShift[W-1:0] - d_q;
                else
                    rem_d = remShift[W-1:0];
                dvd_d = dvd_q << 1;
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == '1)
                    state_d = EVAL;
            end
            EVAL: begin
                if (rem_q == '0) begin
                    if (pNext[W]) begin
                        error_d = 1'b1;
                        state_d = ERROR;
                    end else begin
                        p_d     = pNext[W-1:0];
                        d_d     = TWO_W;
                        dsq_d   = FOUR_S;
                        state_d = CHECK;
                    end
                end else begin
                    if (d_q == TWO_W) begin
                        d_d   = THREE_W;
                        dsq_d = NINE_S;
                    end else begin
                        dsq_d = dsq_q + ({{W{1'b0}}, d_q} << 2) + FOUR_S;
                        d_d   = d_q + TWO_W;
                    end
                    state_d = CHECK;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.ready = (state_q == IDLE) || (state_q == ERROR);
    assign bus.error = error_q;
    assign bus.res   = res_q;
endmodule
